// File: rtl/vhdci_link_trainer.sv
// Multi-lane VHDCI link trainer: IDELAY calibration, eye edge search, centring,
// bitslip alignment, sync handshake and toggle monitoring. Optional macro: VHDCI_LINK_ERRCNT_EN.
module vhdci_link_trainer #(
  parameter int LANES      = 2,
  parameter int WORD_W     = 8,
  parameter int HALF_TAPS  = 15,
  parameter int MAX_TAPS   = 64,
  parameter int LOSS_LIMIT = 3,
  parameter int SLIP_GAP   = 3
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic                           link_en_in,
  input  logic [LANES*(WORD_W-1)-1:0]    tx_data_in,
  output logic [LANES*(WORD_W-1)-1:0]    rx_data_out,
  output logic [LANES-1:0]               lane_synced_out,
  output logic                           link_up_out,
  input  logic [LANES*WORD_W-1:0]        serdes_rx_in,
  output logic [LANES*WORD_W-1:0]        serdes_tx_out,
  output logic [LANES-1:0]               delay_cal_out,
  output logic [LANES-1:0]               delay_ce_out,
  output logic [LANES-1:0]               delay_inc_out,
  input  logic [LANES-1:0]               delay_busy_in,
  output logic [LANES-1:0]               bitslip_out,
  output logic [LANES-1:0]               io_reset_out,
  output logic [15:0]                    err_count_out
);
  localparam int PW     = WORD_W - 1;
  localparam int TAP_W  = $clog2(MAX_TAPS + 1);
  localparam int CTR_W  = $clog2(HALF_TAPS + 1);
  localparam int GAP_W  = $clog2(SLIP_GAP + 2);
  localparam int MISS_W = $clog2(LOSS_LIMIT + 1);
  localparam logic [WORD_W-1:0] TRAIN = WORD_W'(1);
  localparam logic [WORD_W-1:0] ACK   = {1'b1, {(WORD_W-2){1'b0}}, 1'b1};

  // state    | meaning
  // CAL      | release io_reset, pulse IDELAY calibrate
  // CAL_WAIT | wait for calibration to finish, then pulse io_reset
  // REF      | capture first non-zero word as eye reference
  // INC      | step one tap forward
  // INC_WAIT | settle, compare against reference for an eye edge
  // CENTER   | step HALF_TAPS back toward eye centre
  // ALIGN    | bitslip until TRAIN/ACK seen, ACK handshake
  // MON      | toggle-bit link monitoring
  typedef enum logic [2:0] {CAL, CAL_WAIT, REF, INC, INC_WAIT, CENTER, ALIGN, MON} state_t;

  logic [LANES*WORD_W-1:0] rx_q;
  logic [LANES*PW-1:0]     rx_pay;
  logic [LANES-1:0]        busy_q;

`ifdef VHDCI_LINK_ERRCNT_EN
  logic [LANES-1:0] lane_err;
  logic [15:0]      err_cnt;
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rx_q        <= '0;
      busy_q      <= '0;
      rx_data_out <= '0;
      link_up_out <= 1'b0;
    end else begin
      rx_q        <= serdes_rx_in;
      busy_q      <= delay_busy_in;
      rx_data_out <= rx_pay;
      link_up_out <= &lane_synced_out;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    state_t              state_q, state_d;
    logic [WORD_W-1:0]   rx_w, ref_q, ref_d, tx_q, tx_d;
    logic [TAP_W-1:0]    tap_q, tap_d;
    logic [CTR_W-1:0]    ctr_q, ctr_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [MISS_W-1:0]   miss_q, miss_d;
    logic cal_q, cal_d, ce_q, ce_d, inc_q, inc_d, slip_q, slip_d, iorst_q, iorst_d;
    logic ack_q, ack_d, sync_q, sync_d, tog_q, tog_d, arm_q, arm_d, exp_q, exp_d;
    logic idle;

    assign rx_w = rx_q[i*WORD_W +: WORD_W];
    // a tap step is complete only once the pulse is gone and both busy views are low
    assign idle = !ce_q && !delay_busy_in[i] && !busy_q[i];

    assign rx_pay[i*PW +: PW]              = rx_w[PW-1:0];
    assign serdes_tx_out[i*WORD_W +: WORD_W] = tx_q;
    assign lane_synced_out[i] = sync_q;
    assign delay_cal_out[i]   = cal_q;
    assign delay_ce_out[i]    = ce_q;
    assign delay_inc_out[i]   = inc_q;
    assign bitslip_out[i]     = slip_q;
    assign io_reset_out[i]    = iorst_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        state_q <= CAL;
        ref_q   <= '0;
        tx_q    <= '0;
        tap_q   <= '0;
        ctr_q   <= '0;
        gap_q   <= '0;
        miss_q  <= '0;
        cal_q   <= 1'b0;
        ce_q    <= 1'b0;
        inc_q   <= 1'b1;
        slip_q  <= 1'b0;
        iorst_q <= 1'b1;
        ack_q   <= 1'b0;
        sync_q  <= 1'b0;
        tog_q   <= 1'b0;
        arm_q   <= 1'b0;
        exp_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        ref_q   <= ref_d;
        tx_q    <= tx_d;
        tap_q   <= tap_d;
        ctr_q   <= ctr_d;
        gap_q   <= gap_d;
        miss_q  <= miss_d;
        cal_q   <= cal_d;
        ce_q    <= ce_d;
        inc_q   <= inc_d;
        slip_q  <= slip_d;
        iorst_q <= iorst_d;
        ack_q   <= ack_d;
        sync_q  <= sync_d;
        tog_q   <= tog_d;
        arm_q   <= arm_d;
        exp_q   <= exp_d;
      end
    end

    always_comb begin
      state_d = state_q;
      ref_d   = ref_q;
      tx_d    = '0;
      tap_d   = tap_q;
      ctr_d   = ctr_q;
      gap_d   = gap_q;
      miss_d  = miss_q;
      cal_d   = 1'b0;
      ce_d    = 1'b0;
      inc_d   = inc_q;
      slip_d  = 1'b0;
      iorst_d = 1'b0;
      ack_d   = ack_q;
      sync_d  = sync_q;
      tog_d   = tog_q;
      arm_d   = arm_q;
      exp_d   = exp_q;
      if (!link_en_in) begin
        state_d = CAL;
        iorst_d = 1'b1;
        sync_d  = 1'b0;
        arm_d   = 1'b0;
        miss_d  = '0;
        ack_d   = 1'b0;
        gap_d   = '0;
      end else begin
        case (state_q)
          CAL: begin
            cal_d   = 1'b1;
            state_d = CAL_WAIT;
          end
          CAL_WAIT: if (!cal_q && !delay_busy_in[i] && !busy_q[i]) begin
            iorst_d = 1'b1;
            state_d = REF;
          end
          REF: if (rx_w != '0) begin
            ref_d   = rx_w;
            tap_d   = '0;
            state_d = INC;
          end
          INC: begin
            inc_d   = 1'b1;
            ce_d    = 1'b1;
            tap_d   = tap_q + TAP_W'(1);
            state_d = INC_WAIT;
          end
          INC_WAIT: if (idle) begin
            if (rx_w != ref_q || tap_q == TAP_W'(MAX_TAPS)) begin
              inc_d   = 1'b0;
              ctr_d   = '0;
              state_d = CENTER;
            end else begin
              state_d = INC;
            end
          end
          CENTER: if (idle) begin
            if (ctr_q == CTR_W'(HALF_TAPS)) begin
              ack_d   = 1'b0;
              gap_d   = '0;
              state_d = ALIGN;
            end else begin
              ce_d  = 1'b1;
              ctr_d = ctr_q + CTR_W'(1);
            end
          end
          ALIGN: begin
            // gap covers the pulse cycle plus SLIP_GAP idle cycles
            if (gap_q != '0) begin
              gap_d = gap_q - GAP_W'(1);
            end else if (rx_w == ACK && ack_q) begin
              sync_d  = 1'b1;
              arm_d   = 1'b0;
              miss_d  = '0;
              state_d = MON;
            end else if (rx_w == TRAIN || rx_w == ACK) begin
              ack_d = 1'b1;
            end else begin
              slip_d = 1'b1;
              gap_d  = GAP_W'(SLIP_GAP + 1);
              ack_d  = 1'b0;
            end
            tx_d = ack_d ? ACK : TRAIN;
          end
          MON: begin
            tog_d = !tog_q;
            tx_d  = {tog_d, tx_data_in[i*PW +: PW]};
            if (!arm_q) begin
              if (rx_w != ACK) begin
                arm_d = 1'b1;
                exp_d = !rx_w[WORD_W-1];
              end
            end else if (rx_w[WORD_W-1] == exp_q) begin
              miss_d = '0;
              exp_d  = !exp_q;
            end else begin
              exp_d = !rx_w[WORD_W-1];
              if (miss_q == MISS_W'(LOSS_LIMIT - 1)) begin
                sync_d  = 1'b0;
                arm_d   = 1'b0;
                miss_d  = '0;
                ack_d   = 1'b0;
                gap_d   = '0;
                state_d = ALIGN;
              end else begin
                miss_d = miss_q + MISS_W'(1);
              end
            end
          end
          default: state_d = CAL;
        endcase
      end
    end

`ifdef VHDCI_LINK_ERRCNT_EN
    assign lane_err[i] = link_en_in && state_q == MON && arm_q && (rx_w[WORD_W-1] != exp_q);
`endif
  end

`ifdef VHDCI_LINK_ERRCNT_EN
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)                       err_cnt <= '0;
    else if (|lane_err && err_cnt != '1) err_cnt <= err_cnt + 16'd1;
  end
  assign err_count_out = err_cnt;
`else
  assign err_count_out = '0;
`endif
endmodule

// File: tb/tb_vhdci_link_trainer.sv
// Directed bench for vhdci_link_trainer: loopback lanes with a rotating,
// tap-dependent rx model, busy stalls, link loss, restart and reset checks.
`timescale 1ns/1ps
module tb_vhdci_link_trainer;
  localparam int LANES = 2;
  localparam int W     = 8;
  localparam int PW    = W - 1;
`ifdef VHDCI_LINK_ERRCNT_EN
  localparam bit ERRCNT = 1'b1;
`else
  localparam bit ERRCNT = 1'b0;
`endif

  logic                  clk_in = 1'b0;
  logic                  rst_n_in = 1'b1;
  logic                  link_en_in = 1'b0;
  logic [LANES*PW-1:0]   tx_data_in = '0;
  logic [LANES*PW-1:0]   rx_data_out;
  logic [LANES-1:0]      lane_synced_out;
  logic                  link_up_out;
  logic [LANES*W-1:0]    serdes_rx_in;
  logic [LANES*W-1:0]    serdes_tx_out;
  logic [LANES-1:0]      delay_cal_out, delay_ce_out, delay_inc_out;
  logic [LANES-1:0]      delay_busy_in = '0;
  logic [LANES-1:0]      bitslip_out, io_reset_out;
  logic [15:0]           err_count_out;

  always #5 clk_in = ~clk_in;

  vhdci_link_trainer dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .link_en_in(link_en_in),
    .tx_data_in(tx_data_in), .rx_data_out(rx_data_out),
    .lane_synced_out(lane_synced_out), .link_up_out(link_up_out),
    .serdes_rx_in(serdes_rx_in), .serdes_tx_out(serdes_tx_out),
    .delay_cal_out(delay_cal_out), .delay_ce_out(delay_ce_out),
    .delay_inc_out(delay_inc_out), .delay_busy_in(delay_busy_in),
    .bitslip_out(bitslip_out), .io_reset_out(io_reset_out),
    .err_count_out(err_count_out)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // rx model: loopback rotated by the bitslip state; idle line shows a tap-dependent word
  int   tap [LANES] = '{0, 0};
  int   rot [LANES] = '{3, 3};
  int   edge_tap = 20;
  logic corrupt = 1'b0;
  logic corrupt_val = 1'b0;

  function automatic logic [W-1:0] rx_model(input logic [W-1:0] txw, input int tp,
                                            input int rt, input int et);
    if (txw == '0) return (tp >= et) ? 8'h5A : 8'hA5;
    return (txw << rt) | (txw >> (W - rt));
  endfunction

  always_comb begin
    serdes_rx_in = '0;
    for (int l = 0; l < LANES; l++)
      serdes_rx_in[l*W +: W] = rx_model(serdes_tx_out[l*W +: W], tap[l], rot[l], edge_tap);
    if (corrupt) serdes_rx_in[2*W-1] = corrupt_val;
  end

  always @(posedge clk_in) begin
    for (int l = 0; l < LANES; l++) begin
      if (delay_cal_out[l])     tap[l] <= 0;
      else if (delay_ce_out[l]) tap[l] <= delay_inc_out[l] ? tap[l] + 1 : tap[l] - 1;
      if (bitslip_out[l])       rot[l] <= (rot[l] + 1) % W;
    end
  end

  // pulse counters, busy stall driver and ce-while-busy detector
  int   inc_cnt [LANES] = '{0, 0};
  int   dec_cnt [LANES] = '{0, 0};
  int   slip_cnt[LANES] = '{0, 0};
  int   cal_cnt [LANES] = '{0, 0};
  int   stall_viol = 0;
  int   stall_left = 0;
  logic stall_en = 1'b0;
  logic b1 = 1'b0;

  always @(negedge clk_in) begin
    for (int l = 0; l < LANES; l++) begin
      if (delay_ce_out[l] && delay_inc_out[l])  inc_cnt[l] <= inc_cnt[l] + 1;
      if (delay_ce_out[l] && !delay_inc_out[l]) dec_cnt[l] <= dec_cnt[l] + 1;
      if (bitslip_out[l])   slip_cnt[l] <= slip_cnt[l] + 1;
      if (delay_cal_out[l]) cal_cnt[l]  <= cal_cnt[l] + 1;
    end
    if (|delay_ce_out && (|delay_busy_in || b1)) stall_viol <= stall_viol + 1;
    b1 <= |delay_busy_in;
    if (stall_en && |delay_ce_out) begin
      stall_left    <= 9;
      delay_busy_in <= '1;
    end else if (stall_left > 0) begin
      stall_left    <= stall_left - 1;
      delay_busy_in <= '1;
    end else begin
      delay_busy_in <= '0;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic stuck_lane1(input int n);
    corrupt_val = ~serdes_tx_out[2*W-1];
    corrupt = 1'b1;
    cycles(n);
    corrupt = 1'b0;
  endtask

  initial begin
    int n;
    int inc0, dec0, cal0, cal1;
    logic [15:0] err_exp;

    #1 rst_n_in = 1'b0;
    #2;
    check("rst_io_reset", io_reset_out, 2'b11);
    check("rst_delay_inc", delay_inc_out, 2'b11);
    check("rst_outputs_zero", {lane_synced_out, link_up_out, delay_cal_out, delay_ce_out, bitslip_out}, 0);
    check("rst_tx_zero", serdes_tx_out, 0);

    // bring-up with an eye edge at tap 20 and a 3-bit rotation
    tx_data_in = {7'h2A, 7'h55};
    link_en_in = 1'b1;
    cycles(2);
    rst_n_in = 1'b1;
    n = 0;
    while (lane_synced_out !== 2'b11 && n < 3000) begin @(negedge clk_in); n++; end
    check("sync_a", lane_synced_out, 2'b11);
    check("link_up_lag", link_up_out, 1'b0);
    @(negedge clk_in);
    check("link_up_a", link_up_out, 1'b1);
    cycles(10);
    check("inc_cnt0", inc_cnt[0], 21);
    check("inc_cnt1", inc_cnt[1], 21);
    check("dec_cnt0", dec_cnt[0], 15);
    check("dec_cnt1", dec_cnt[1], 15);
    check("slip_cnt0", slip_cnt[0], 5);
    check("slip_cnt1", slip_cnt[1], 5);
    check("cal_cnt_a", cal_cnt[0] + cal_cnt[1], 2);
    check("rx_data_loop", rx_data_out, {7'h2A, 7'h55});

    // two stuck toggle bits: tolerated
    stuck_lane1(2);
    cycles(6);
    check("synced_after_2", lane_synced_out, 2'b11);
    err_exp = ERRCNT ? 16'd2 : 16'd0;
    check("err_after_2", err_count_out, err_exp);

    // three stuck toggle bits: lane 1 drops and realigns without recalibration
    cal0 = cal_cnt[0];
    cal1 = cal_cnt[1];
    stuck_lane1(3);
    n = 0;
    while (lane_synced_out[1] !== 1'b0 && n < 20) begin @(negedge clk_in); n++; end
    check("lane1_drop", lane_synced_out, 2'b01);
    check("link_up_before_drop", link_up_out, 1'b1);
    @(negedge clk_in);
    check("link_up_drop", link_up_out, 1'b0);
    err_exp = ERRCNT ? 16'd5 : 16'd0;
    check("err_after_3", err_count_out, err_exp);
    n = 0;
    while (link_up_out !== 1'b1 && n < 500) begin @(negedge clk_in); n++; end
    check("relock", lane_synced_out, 2'b11);
    check("no_recal", (cal_cnt[0] - cal0) + (cal_cnt[1] - cal1), 0);

`ifdef VHDCI_LINK_ERRCNT_EN
    force dut.err_cnt = 16'hFFFF;
    @(negedge clk_in);
    release dut.err_cnt;
    cycles(5);
    stuck_lane1(1);
    cycles(5);
    check("err_saturate", err_count_out, 16'hFFFF);
`endif

    // asynchronous reset mid-MON
    #2 rst_n_in = 1'b0;
    #1;
    check("amid_io_reset", io_reset_out, 2'b11);
    check("amid_delay_inc", delay_inc_out, 2'b11);
    check("amid_zero", {lane_synced_out, link_up_out, delay_cal_out, delay_ce_out, bitslip_out}, 0);
    check("amid_data_zero", {serdes_tx_out, rx_data_out, err_count_out}, 0);

    // no eye edge, busy stall of 10 cycles after every ce
    edge_tap = 1000;
    stall_en = 1'b1;
    @(negedge clk_in);
    inc0 = inc_cnt[0];
    dec0 = dec_cnt[0];
    rst_n_in = 1'b1;
    n = 0;
    while (link_up_out !== 1'b1 && n < 5000) begin @(negedge clk_in); n++; end
    check("link_up_b", link_up_out, 1'b1);
    cycles(2);
    check("inc_cnt_max", inc_cnt[0] - inc0, 64);
    check("dec_cnt_b", dec_cnt[0] - dec0, 15);
    check("no_ce_while_busy", stall_viol, 0);

    // restart during INC_WAIT
    stall_en = 1'b0;
    link_en_in = 1'b0;
    cycles(12);
    link_en_in = 1'b1;
    n = 0;
    while (!(delay_ce_out[0] && delay_inc_out[0]) && n < 300) begin @(negedge clk_in); n++; end
    check("reach_inc_wait", delay_ce_out[0], 1'b1);
    link_en_in = 1'b0;
    @(negedge clk_in);
    check("en_off_io_reset", io_reset_out, 2'b11);
    check("en_off_synced", lane_synced_out, 2'b00);
    cycles(3);
    check("en_off_hold", {delay_cal_out, delay_ce_out, io_reset_out}, 6'b0000_11);
    link_en_in = 1'b1;
    @(negedge clk_in);
    check("en_on_cal", delay_cal_out, 2'b11);
    check("en_on_io_reset", io_reset_out, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
